// File: rtl/sqrt_round_pack_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sqrt_round_pack_if : handshake/data bundle for the sqrt rounding stage   |
// | Optional rnd_mode field when SQRT_RND_MODES_EN is defined. Rev 1.0       |
// +--------------------------------------------------------------------------+
interface sqrt_round_pack_if #(
  parameter int SIG_WIDTH = 23,
  parameter int EXP_WIDTH = 8
);
  logic                               in_valid;
  logic                               in_ready;
  logic [SIG_WIDTH+2:0]               in_sig;
  logic [EXP_WIDTH-1:0]               in_exp;
  logic                               in_sign;
  logic                               in_is_nan;
  logic                               in_is_inf;
  logic                               in_is_zero;
`ifdef SQRT_RND_MODES_EN
  logic [1:0]                         rnd_mode;
`endif
  logic                               out_valid;
  logic                               out_ready;
  logic [SIG_WIDTH+EXP_WIDTH:0]       z;
  logic                               inexact;
  logic                               invalid;

  modport slave (
`ifdef SQRT_RND_MODES_EN
    input  rnd_mode,
`endif
    input  in_valid, in_sig, in_exp, in_sign, in_is_nan, in_is_inf, in_is_zero,
    output in_ready,
    output out_valid, z, inexact, invalid,
    input  out_ready
  );

  modport master (
`ifdef SQRT_RND_MODES_EN
    output rnd_mode,
`endif
    output in_valid, in_sig, in_exp, in_sign, in_is_nan, in_is_inf, in_is_zero,
    input  in_ready,
    input  out_valid, z, inexact, invalid,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/sqrt_round_pack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sqrt_round_pack : two-stage round/special-case/pack stage of fp sqrt.    |
// | SQRT_RND_MODES_EN adds RTZ/RUP/RDN via rnd_mode (default RNE). Rev 1.0   |
// +--------------------------------------------------------------------------+
module sqrt_round_pack #(
  parameter int SIG_WIDTH = 23,
  parameter int EXP_WIDTH = 8
) (
  input  logic              clk,
  input  logic              resetn,
  sqrt_round_pack_if.slave  pipe
);
  localparam int ZW = SIG_WIDTH + EXP_WIDTH + 1;
  localparam logic [EXP_WIDTH:0] BIAS_EXT = (EXP_WIDTH+1)'((1 << (EXP_WIDTH-1)) - 1);
  localparam logic [ZW-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};
  localparam logic [ZW-1:0] PINF = {1'b0, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};

  // Stage 1 registers
  logic                 s1_valid_q, s1_valid_d;
  logic [SIG_WIDTH+2:0] s1_sig_q, s1_sig_d;
  logic [EXP_WIDTH-1:0] s1_exp_q, s1_exp_d;
  logic                 s1_sign_q, s1_sign_d;
  logic                 s1_nan_q, s1_nan_d;
  logic                 s1_inf_q, s1_inf_d;
  logic                 s1_zero_q, s1_zero_d;
`ifdef SQRT_RND_MODES_EN
  logic [1:0]           s1_rnd_q, s1_rnd_d;
`endif

  // Stage 2 registers
  logic                 s2_valid_q, s2_valid_d;
  logic [ZW-1:0]        z_q, z_d;
  logic                 inexact_q, inexact_d;
  logic                 invalid_q, invalid_d;

  logic s2_adv_w, s1_to_s2_w, in_fire_w;

  assign s2_adv_w      = !s2_valid_q | pipe.out_ready;
  assign s1_to_s2_w    = s1_valid_q & s2_adv_w;
  assign pipe.in_ready = !s1_valid_q | s1_to_s2_w;
  assign in_fire_w     = pipe.in_valid & pipe.in_ready;

  always_comb begin
    s1_valid_d = in_fire_w | (s1_valid_q & !s1_to_s2_w);
    s1_sig_d   = s1_sig_q;
    s1_exp_d   = s1_exp_q;
    s1_sign_d  = s1_sign_q;
    s1_nan_d   = s1_nan_q;
    s1_inf_d   = s1_inf_q;
    s1_zero_d  = s1_zero_q;
`ifdef SQRT_RND_MODES_EN
    s1_rnd_d   = s1_rnd_q;
`endif
    if (in_fire_w) begin
      s1_sig_d  = pipe.in_sig;
      s1_exp_d  = pipe.in_exp;
      s1_sign_d = pipe.in_sign;
      s1_nan_d  = pipe.in_is_nan;
      s1_inf_d  = pipe.in_is_inf;
      s1_zero_d = pipe.in_is_zero;
`ifdef SQRT_RND_MODES_EN
      s1_rnd_d  = pipe.rnd_mode;
`endif
    end
  end

  // Rounding and exponent halving on the S1 contents
  logic                 lsb_w, g_w, s_w, inc_w;
  logic [SIG_WIDTH:0]   mant_w;
  logic [SIG_WIDTH+1:0] mant_inc_w;
  logic [EXP_WIDTH:0]   exp_sum_w;
  logic [EXP_WIDTH-1:0] e_res_w;
  logic [1:0]           unused_bits_w;

  always_comb begin
    lsb_w  = s1_sig_q[2];
    g_w    = s1_sig_q[1];
    s_w    = s1_sig_q[0];
    mant_w = s1_sig_q[SIG_WIDTH+2:2];
    inc_w  = g_w & (s_w | lsb_w);
`ifdef SQRT_RND_MODES_EN
    // Finite roots are positive, so RUP rounds away from zero and RDN truncates.
    case (s1_rnd_q)
      2'b00:   inc_w = g_w & (s_w | lsb_w);
      2'b10:   inc_w = g_w | s_w;
      default: inc_w = 1'b0;
    endcase
`endif
    mant_inc_w = {1'b0, mant_w} + {{(SIG_WIDTH+1){1'b0}}, inc_w};
    exp_sum_w  = {1'b0, s1_exp_q} + BIAS_EXT;
    e_res_w    = exp_sum_w[EXP_WIDTH:1];
  end

  assign unused_bits_w = {mant_inc_w[SIG_WIDTH], exp_sum_w[0]};

  always_comb begin
    s2_valid_d = s2_valid_q;
    z_d        = z_q;
    inexact_d  = inexact_q;
    invalid_d  = invalid_q;
    if (s2_adv_w) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_to_s2_w) begin
      inexact_d = 1'b0;
      invalid_d = 1'b0;
      if (s1_nan_q) begin
        z_d = QNAN;
      end else if (s1_zero_q) begin
        z_d = {s1_sign_q, {(ZW-1){1'b0}}};
      end else if (s1_sign_q) begin
        z_d       = QNAN;
        invalid_d = 1'b1;
      end else if (s1_inf_q) begin
        z_d = PINF;
      end else begin
        inexact_d = g_w | s_w;
        if (mant_inc_w[SIG_WIDTH+1]) begin
          z_d = {1'b0, e_res_w + EXP_WIDTH'(1), {SIG_WIDTH{1'b0}}};
        end else begin
          z_d = {1'b0, e_res_w, mant_inc_w[SIG_WIDTH-1:0]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_sig_q   <= '0;
      s1_exp_q   <= '0;
      s1_sign_q  <= 1'b0;
      s1_nan_q   <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
`ifdef SQRT_RND_MODES_EN
      s1_rnd_q   <= 2'b00;
`endif
      s2_valid_q <= 1'b0;
      z_q        <= '0;
      inexact_q  <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sig_q   <= s1_sig_d;
      s1_exp_q   <= s1_exp_d;
      s1_sign_q  <= s1_sign_d;
      s1_nan_q   <= s1_nan_d;
      s1_inf_q   <= s1_inf_d;
      s1_zero_q  <= s1_zero_d;
`ifdef SQRT_RND_MODES_EN
      s1_rnd_q   <= s1_rnd_d;
`endif
      s2_valid_q <= s2_valid_d;
      z_q        <= z_d;
      inexact_q  <= inexact_d;
      invalid_q  <= invalid_d;
    end
  end

  assign pipe.out_valid = s2_valid_q;
  assign pipe.z         = z_q;
  assign pipe.inexact   = inexact_q;
  assign pipe.invalid   = invalid_q;
endmodule
`default_nettype wire

// File: tb/tb_sqrt_round_pack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sqrt_round_pack : directed vectors checked against literals and a     |
// | behavioural rounding model; SQRT_RND_MODES_EN adds mode vectors. Rev 1.0 |
// +--------------------------------------------------------------------------+
module tb_sqrt_round_pack;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sqrt_round_pack_if #(.SIG_WIDTH(23), .EXP_WIDTH(8)) bus ();
  sqrt_round_pack #(.SIG_WIDTH(23), .EXP_WIDTH(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .pipe   (bus.slave)
  );

  typedef struct packed {
    logic [31:0] z;
    logic        inexact;
    logic        invalid;
  } res_t;

  int   total = 0;
  int   bad = 0;
  int   accepted = 0;
  int   emitted = 0;
  int   guard;
  int   tog_c;
  int   bp_start;
  logic rdy;
  logic bp_done;
  logic stall_prev = 1'b0;
  res_t held;
  res_t popped;
  res_t exp_q[$];
  logic [1:0] tb_mode;

  logic [25:0] bp_sig [8];
  logic [7:0]  bp_exp [8];
  logic        bp_pat [4];

  // Square root rounding rules applied to the integer root value and its remainder.
  function automatic res_t model(logic [25:0] sig, logic [7:0] e, logic sign,
                                 logic nan, logic inf, logic zero, logic [1:0] mode);
    res_t        r;
    int unsigned m, rem, ee;
    bit          up;
    r = '0;
    if (nan) begin
      r.z = 32'h7FC00000;
    end else if (zero) begin
      r.z = {sign, 31'h0};
    end else if (sign) begin
      r.z = 32'h7FC00000;
      r.invalid = 1'b1;
    end else if (inf) begin
      r.z = 32'h7F800000;
    end else begin
      m   = 32'(sig) / 4;
      rem = 32'(sig) % 4;
      ee  = (32'(e) + 127) / 2;
      case (mode)
        2'b00:   up = (rem > 2) || (rem == 2 && (m % 2) == 1);
        2'b10:   up = (rem != 0);
        default: up = 1'b0;
      endcase
      m = m + 32'(up);
      if (m == (1 << 24)) begin
        m  = 1 << 23;
        ee = ee + 1;
      end
      r.z       = {1'b0, 8'(ee), 23'(m)};
      r.inexact = (rem != 0);
    end
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic drive(logic [25:0] sig, logic [7:0] e, logic sign,
                       logic nan, logic inf, logic zero, logic [1:0] mode);
    bus.in_sig     = sig;
    bus.in_exp     = e;
    bus.in_sign    = sign;
    bus.in_is_nan  = nan;
    bus.in_is_inf  = inf;
    bus.in_is_zero = zero;
    tb_mode        = mode;
`ifdef SQRT_RND_MODES_EN
    bus.rnd_mode   = mode;
`endif
  endtask

  // Scoreboard: every transfer at both ends and every stalled cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      accepted   = 0;
      emitted    = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_z", bus.z, held.z);
        check("stall_flags", {30'd0, bus.inexact, bus.invalid}, {30'd0, held.inexact, held.invalid});
      end
      check("in_ready_rule", 32'(bus.in_ready),
            32'(!((accepted - emitted) == 2 && !bus.out_ready)));
      if (bus.in_valid && bus.in_ready) begin
`ifdef SQRT_RND_MODES_EN
        exp_q.push_back(model(bus.in_sig, bus.in_exp, bus.in_sign, bus.in_is_nan,
                              bus.in_is_inf, bus.in_is_zero, bus.rnd_mode));
`else
        exp_q.push_back(model(bus.in_sig, bus.in_exp, bus.in_sign, bus.in_is_nan,
                              bus.in_is_inf, bus.in_is_zero, 2'b00));
`endif
        accepted++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 32'd1, 32'd0);
        end else begin
          popped = exp_q.pop_front();
          check("model_z", bus.z, popped.z);
          check("model_flags", {30'd0, bus.inexact, bus.invalid},
                {30'd0, popped.inexact, popped.invalid});
        end
        emitted++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = '{bus.z, bus.inexact, bus.invalid};
    end
  end

  task automatic run_one(string name, logic [25:0] sig, logic [7:0] e, logic sign,
                         logic nan, logic inf, logic zero, logic [1:0] mode,
                         logic [31:0] lz, logic linx, logic linv);
    int cyc;
    drive(sig, e, sign, nan, inf, zero, mode);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'd2);
    check({name, "_z"}, bus.z, lz);
    check({name, "_inexact"}, 32'(bus.inexact), 32'(linx));
    check({name, "_invalid"}, 32'(bus.invalid), 32'(linv));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bp_sig = '{26'h2000000, 26'h2D413CD, 26'h2000006, 26'h3FFFFFE,
               26'h2ABCDEF, 26'h3123457, 26'h2000005, 26'h3FFFFFF};
    bp_exp = '{8'd129, 8'd128, 8'd127, 8'd127, 8'd100, 8'd200, 8'd1, 8'd254};
    bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(26'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_z", bus.z, 32'h0);
    check("reset_flags", {30'd0, bus.inexact, bus.invalid}, 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Literal pins on the model itself
    check("pin_model_sqrt2", model(26'h2D413CD, 8'd128, 0, 0, 0, 0, 2'b00).z, 32'h3FB504F3);
    check("pin_model_tie", model(26'h2000006, 8'd127, 0, 0, 0, 0, 2'b00).z, 32'h3F800002);
    check("pin_model_neg", model(26'h2000000, 8'd127, 1, 0, 0, 0, 2'b00).z, 32'h7FC00000);

    run_one("sqrt4",   26'h2000000, 8'd129, 0, 0, 0, 0, 2'b00, 32'h40000000, 0, 0);
    run_one("sqrt2",   26'h2D413CD, 8'd128, 0, 0, 0, 0, 2'b00, 32'h3FB504F3, 1, 0);
    run_one("tie_rne", 26'h2000006, 8'd127, 0, 0, 0, 0, 2'b00, 32'h3F800002, 1, 0);
    run_one("carry",   26'h3FFFFFE, 8'd127, 0, 0, 0, 0, 2'b00, 32'h40000000, 1, 0);
    run_one("neg",     26'h2000000, 8'd127, 1, 0, 0, 0, 2'b00, 32'h7FC00000, 0, 1);
    run_one("negzero", 26'h0,       8'd0,   1, 0, 0, 1, 2'b00, 32'h80000000, 0, 0);
    run_one("pinf",    26'h0,       8'd255, 0, 0, 1, 0, 2'b00, 32'h7F800000, 0, 0);
    run_one("nan",     26'h2400000, 8'd255, 0, 1, 0, 0, 2'b00, 32'h7FC00000, 0, 0);
    run_one("negnan",  26'h2400000, 8'd255, 1, 1, 0, 0, 2'b00, 32'h7FC00000, 0, 0);
`ifdef SQRT_RND_MODES_EN
    run_one("tie_rtz", 26'h2000006, 8'd127, 0, 0, 0, 0, 2'b01, 32'h3F800001, 1, 0);
    run_one("rup",     26'h2000001, 8'd127, 0, 0, 0, 0, 2'b10, 32'h3F800001, 1, 0);
    run_one("rdn",     26'h2000007, 8'd127, 0, 0, 0, 0, 2'b11, 32'h3F800001, 1, 0);
`endif

    // Back-to-back stream under a 1,0,0,1 out_ready pattern
    bp_start = emitted;
    bp_done  = 1'b0;
    tog_c    = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          drive(bp_sig[i], bp_exp[i], 0, 0, 0, 0, 2'(i % 3));
          bus.in_valid = 1'b1;
          guard = 0;
          do begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
          end while (!rdy && guard < 50);
          if (!rdy) check("bp_accept_timeout", 32'd0, 32'd1);
        end
        bus.in_valid = 1'b0;
        guard = 0;
        while (emitted != accepted && guard < 100) begin
          @(posedge clk);
          #1;
          guard++;
        end
        check("bp_result_count", 32'(emitted - bp_start), 32'd8);
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          bus.out_ready = bp_pat[tog_c % 4];
          tog_c++;
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    @(posedge clk);
    #1;

    // Reset with two results in flight
    bus.out_ready = 1'b0;
    drive(26'h2D413CD, 8'd128, 0, 0, 0, 0, 2'b00);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(26'h2000000, 8'd129, 0, 0, 0, 0, 2'b00);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("inflight_valid", 32'(bus.out_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_valid", 32'(bus.out_valid), 32'd0);
    check("async_reset_z", bus.z, 32'h0);
    check("async_reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("post_reset_no_stale", 32'(bus.out_valid), 32'd0);
    end
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
